sda_kernel_control_regs: RTL and testbench

SDA_KERNEL_CONTROL_REGS -- requirements
Module: sda_kernel_control_regs

---
 rtl/sda_kernel_control_regs.sv | 82 ++++++++
 tb/tb_sda_kernel_control_regs.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sda_kernel_control_regs.sv
// sda_kernel_control_regs: host register block driving the kernel go/done handshake, with run counter and interrupt
module sda_kernel_control_regs #(
  parameter int RegAddrWidth = 5
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    hostWrValid,
  input  logic [RegAddrWidth-1:0] hostWrAddr,
  input  logic [31:0]             hostWrData,
  input  logic                    hostRdValid,
  input  logic [RegAddrWidth-1:0] hostRdAddr,
  output logic [31:0]             hostRdData,
  output logic                    hostRdDataValid,
  output logic                    regGoValid,
  input  logic                    regGoHoldoff,
  input  logic                    regDoneValid,
  output logic                    regDoneStop,
  output logic                    interrupt
);
  typedef enum logic [1:0] {Idle, GoPending, Running} state_t;
  localparam logic [RegAddrWidth-1:0] CtrlAddr = RegAddrWidth'(32'h00);
  localparam logic [RegAddrWidth-1:0] GieAddr  = RegAddrWidth'(32'h04);
  localparam logic [RegAddrWidth-1:0] IerAddr  = RegAddrWidth'(32'h08);
  localparam logic [RegAddrWidth-1:0] IsrAddr  = RegAddrWidth'(32'h0C);
  localparam logic [RegAddrWidth-1:0] CntAddr  = RegAddrWidth'(32'h10);
  state_t state, stateNext;
  logic [31:0] runCount, rdMux;
  logic gie, ier, isr, apDone;
  logic wrCtrl, wrGie, wrIer, wrIsr, rdCtrl, goAccept, doneAccept;
  logic unusedWrBits;
  assign unusedWrBits = &{1'b0, hostWrData[31:1]};
  assign wrCtrl = hostWrValid && hostWrAddr == CtrlAddr;
  assign wrGie  = hostWrValid && hostWrAddr == GieAddr;
  assign wrIer  = hostWrValid && hostWrAddr == IerAddr;
  assign wrIsr  = hostWrValid && hostWrAddr == IsrAddr;
  assign rdCtrl = hostRdValid && hostRdAddr == CtrlAddr;
  assign goAccept   = state == GoPending && regGoValid && !regGoHoldoff;
  assign doneAccept = state == Running && regDoneValid && !regDoneStop;
  always_comb begin
    stateNext = state;
    stateNext = doneAccept ? Idle :
                goAccept ? Running :
                (state == Idle && wrCtrl && hostWrData[0]) ? GoPending : state;
  end
  // Reads observe register contents before any same-cycle write or clear
  always_comb begin
    rdMux = '0;
    rdMux = hostRdAddr == CtrlAddr ? {29'b0, state == Idle, apDone, state != Idle} :
            hostRdAddr == GieAddr  ? {31'b0, gie} :
            hostRdAddr == IerAddr  ? {31'b0, ier} :
            hostRdAddr == IsrAddr  ? {31'b0, isr} :
            hostRdAddr == CntAddr  ? runCount : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state           <= Idle;
      regGoValid      <= 1'b0;
      regDoneStop     <= 1'b1;
      gie             <= 1'b0;
      ier             <= 1'b0;
      isr             <= 1'b0;
      apDone          <= 1'b0;
      runCount        <= '0;
      interrupt       <= 1'b0;
      hostRdDataValid <= 1'b0;
      hostRdData      <= '0;
    end else begin
      state       <= stateNext;
      regGoValid  <= stateNext == GoPending;
      regDoneStop <= stateNext != Running;
      if (wrGie) gie <= hostWrData[0];
      if (wrIer) ier <= hostWrData[0];
      isr <= (doneAccept && ier) ? 1'b1 : (wrIsr && hostWrData[0]) ? ~isr : isr;
      apDone <= doneAccept | (apDone & ~rdCtrl);
      runCount <= goAccept ? 32'd0 :
                  (state == Running && runCount != 32'hFFFF_FFFF) ? runCount + 32'd1 : runCount;
      interrupt <= gie & isr;
      hostRdDataValid <= hostRdValid;
      if (hostRdValid) hostRdData <= rdMux;
    end
  end
endmodule

// File: tb/tb_sda_kernel_control_regs.sv
// tb_sda_kernel_control_regs: randomized bench with a behavioural register/handshake model and read scoreboard
module tb_sda_kernel_control_regs;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic srst = 1'b1, hostWrValid = 1'b0, hostRdValid = 1'b0, regGoHoldoff = 1'b0, regDoneValid = 1'b0;
  logic [AW-1:0] hostWrAddr = '0, hostRdAddr = '0;
  logic [31:0] hostWrData = '0, hostRdData;
  logic hostRdDataValid, regGoValid, regDoneStop, interrupt;
  bit mPend, mRun, mGie, mIer, mIsr, mDone, mIrq, mRdV;
  bit [31:0] mCnt, mHold;
  bit [31:0] expQ[$];
  int checks = 0, errors = 0;

  sda_kernel_control_regs #(.RegAddrWidth(AW)) dut (
    .clk(clk), .srst(srst),
    .hostWrValid(hostWrValid), .hostWrAddr(hostWrAddr), .hostWrData(hostWrData),
    .hostRdValid(hostRdValid), .hostRdAddr(hostRdAddr),
    .hostRdData(hostRdData), .hostRdDataValid(hostRdDataValid),
    .regGoValid(regGoValid), .regGoHoldoff(regGoHoldoff),
    .regDoneValid(regDoneValid), .regDoneStop(regDoneStop), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] regVal(input bit [AW-1:0] a);
    case (a)
      5'h00: return {29'd0, !mPend && !mRun, mDone, mPend || mRun};
      5'h04: return {31'd0, mGie};
      5'h08: return {31'd0, mIer};
      5'h0C: return {31'd0, mIsr};
      5'h10: return mCnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs and advance the model across the coming clock edge
  task automatic step(input bit rst, input bit wv, input bit [AW-1:0] wa, input bit [31:0] wd,
                      input bit rv, input bit [AW-1:0] ra, input bit ho, input bit dv);
    bit goAcc, doneAcc, idle;
    @(negedge clk);
    srst = rst; hostWrValid = wv; hostWrAddr = wa; hostWrData = wd;
    hostRdValid = rv; hostRdAddr = ra; regGoHoldoff = ho; regDoneValid = dv;
    if (rst) begin
      {mPend, mRun, mGie, mIer, mIsr, mDone, mIrq, mRdV} = '0;
      mCnt = 0; mHold = 0;
    end else begin
      goAcc = mPend && !ho;
      doneAcc = mRun && dv;
      idle = !mPend && !mRun;
      mRdV = rv;
      if (rv) begin
        expQ.push_back(regVal(ra));
        mHold = regVal(ra);
      end
      mIrq = mGie & mIsr;
      if (doneAcc && mIer) mIsr = 1;
      else if (wv && wa == 5'h0C && wd[0]) mIsr = !mIsr;
      mDone = doneAcc || (mDone && !(rv && ra == 5'h00));
      if (wv && wa == 5'h04) mGie = wd[0];
      if (wv && wa == 5'h08) mIer = wd[0];
      if (goAcc) mCnt = 0;
      else if (mRun && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
      if (doneAcc) mRun = 0;
      else if (goAcc) begin mPend = 0; mRun = 1; end
      else if (idle && wv && wa == 5'h00 && wd[0]) mPend = 1;
    end
  endtask

  task automatic cyc(input bit ho, input bit dv);
    step(0, 0, 0, 0, 0, 0, ho, dv);
  endtask
  task automatic wr(input bit [AW-1:0] a, input bit [31:0] d, input bit ho);
    step(0, 1, a, d, 0, 0, ho, 0);
  endtask
  task automatic rd(input bit [AW-1:0] a, input bit dv);
    step(0, 0, 0, 0, 1, a, 0, dv);
  endtask

  function automatic bit [AW-1:0] pickAddr();
    int r = $urandom_range(0, 6);
    return r < 5 ? AW'(r * 4) : AW'($urandom);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("regGoValid", {31'd0, regGoValid}, {31'd0, mPend});
      chk("regDoneStop", {31'd0, regDoneStop}, {31'd0, !mRun});
      chk("interrupt", {31'd0, interrupt}, {31'd0, mIrq});
      chk("hostRdDataValid", {31'd0, hostRdDataValid}, {31'd0, mRdV});
      if (hostRdDataValid === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdUnexpected at %0t: got data %h expected no response", $time, hostRdData);
        end else chk("hostRdData", hostRdData, expQ.pop_front());
      end else chk("hostRdHold", hostRdData, mHold);
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    rd(5'h00, 0);
    wr(5'h00, 32'h1, 0);
    rd(5'h00, 0);
    repeat (9) cyc(0, 0);
    cyc(0, 1);
    rd(5'h10, 0); rd(5'h00, 0); rd(5'h00, 0);
    wr(5'h00, 32'h1, 1);
    repeat (5) cyc(1, 0);
    rd(5'h00, 0);
    cyc(0, 0);
    wr(5'h00, 32'h1, 0);
    cyc(0, 1);
    wr(5'h04, 32'h1, 0); wr(5'h08, 32'h1, 0);
    wr(5'h00, 32'h1, 0);
    repeat (4) cyc(0, 0);
    rd(5'h00, 1);
    rd(5'h00, 0);
    repeat (2) cyc(0, 0);
    rd(5'h0C, 0);
    wr(5'h0C, 32'h1, 0);
    repeat (3) cyc(0, 0);
    wr(5'h0C, 32'h1, 0);
    step(0, 1, 5'h0C, 32'h1, 1, 5'h0C, 0, 0);
    rd(5'h03, 0); wr(5'h14, 32'hFFFF_FFFF, 0); rd(5'h14, 0);
    wr(5'h00, 32'h1, 1);
    cyc(1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    rd(5'h00, 0);
    repeat (3000) begin
      bit rv = $urandom_range(0, 9) < 4;
      bit wv = $urandom_range(0, 9) < 3;
      bit [AW-1:0] wa = pickAddr();
      bit [AW-1:0] ra = pickAddr();
      bit [31:0] wd = $urandom;
      step($urandom_range(0, 199) == 0, wv, wa, wd, rv, ra,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end
    repeat (3) cyc(0, 0);
    @(negedge clk);
    chk("scoreboardDrained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
